inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the decode/execute datapath.
- Owns the fetch PC and drives the instruction-memory address; imem returns the word combinationally in the same cycle.
- Buffers fetched words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Branch/jump resolution downstream redirects fetch and flushes the buffer.

Parameters:
- XLEN, 64, width of PC and addresses.
- RESET_PC, 64'd0, fetch PC loaded on reset.
- QUEUE_DEPTH, 2, FIFO entries; must be ≥2 and a power of two.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- imem_addr  output  XLEN  instruction-memory address, equal to the fetch PC register.
- imem_inst  input  32  instruction word at imem_addr, valid in the same cycle.
- redirect_valid  input  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  input  XLEN  redirect target.
- inst_valid  output  1  head entry available to decode.
- inst_ready  input  1  decode accepts the head entry this cycle.
- inst_out  output  32  head instruction word.
- inst_pc  output  XLEN  PC of the head instruction.
- queue_count  output  $clog2(QUEUE_DEPTH+1)  current occupancy.

Behaviour:
- Reset low (asynchronous, no clock needed):
  - fetch PC = RESET_PC.
  - Read and write pointers = 0; count = 0.
  - inst_valid = 0, inst_out = 0, inst_pc = 0, queue_count = 0.
- Reset is honoured mid-operation: any in-flight entries are discarded immediately.
- imem_addr is the fetch PC register, taken straight from a flop.
- inst_valid = (count != 0).
- inst_out / inst_pc present the head entry, and are forced to 0 when the queue is empty.
- Dequeue (deq) when inst_valid && inst_ready; the head pointer advances.
- Enqueue (enq) when !redirect_valid && (count < QUEUE_DEPTH || deq):
  - push {fetch PC, imem_inst} at the tail;
  - fetch PC += 4, wrapping modulo 2^XLEN.
- Full with simultaneous deq: enq is allowed, count is unchanged. There is no bubble at steady state.
- Not full and not deq: enq only, count +1.
- Full and no deq: no enq; fetch PC and imem_addr hold.
- Redirect (has priority over enq):
  - On the edge: all entries dropped, pointers reset to 0, count = 0.
  - fetch PC = {redirect_pc[XLEN-1:2], 2'b00}; a misaligned target is silently aligned.
  - A deq in the redirect cycle still counts as accepted by decode; the queue is emptied regardless.
- Latency:
  - A word fetched in cycle N is visible on inst_out in cycle N+1. There is no combinational bypass from imem_inst to inst_out.
  - After a redirect, the first new instruction is valid 2 cycles after the redirect cycle: the queue is empty for 1 cycle.
- Empty with inst_ready = 1: no deq; the queue fills normally.
- Pointers wrap at QUEUE_DEPTH.
- Count never exceeds QUEUE_DEPTH and never goes below 0. Verification asserts both.
- No combinational path from inst_ready or redirect_valid to any output.

Test Plan:
- Reset low, RESET_PC=0:
  - while reset is low: imem_addr=0, inst_valid=0, queue_count=0.
  - 1 cycle after release: inst_valid=1, inst_pc=0, queue_count=1.
- inst_ready held 1, imem returns addr-derived words: inst_pc sequence 0,4,8,12 on consecutive cycles; queue_count steady at 1.
- inst_ready held 0 from reset release:
  - queue_count reaches 2 after 2 edges;
  - imem_addr holds at 8;
  - inst_pc stays 0.
- Queue full (entries for PCs 0,4), then inst_ready=1 for one cycle:
  - next cycle inst_pc=4, queue_count=2;
  - imem_addr=12.
- Queue full, redirect_valid=1 with redirect_pc=0x43:
  - next cycle inst_valid=0, queue_count=0, imem_addr=0x40;
  - cycle after: inst_pc=0x40, inst_valid=1.
- Reset pulsed low between clock edges while queue_count=2: inst_valid drops to 0 and imem_addr=RESET_PC before the next edge.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, drives imem, and buffers
// fetched {pc, inst} pairs in a small FIFO that feeds decode over valid/ready.
// A downstream redirect flushes the FIFO and restarts fetch at an aligned target.
module inst_fetch_queue #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              QUEUE_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic [XLEN-1:0]                  imem_addr,
    input  logic [31:0]                      imem_inst,
    input  logic                             redirect_valid,
    input  logic [XLEN-1:0]                  redirect_pc,
    output logic                             inst_valid,
    input  logic                             inst_ready,
    output logic [31:0]                      inst_out,
    output logic [XLEN-1:0]                  inst_pc,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     q_inst [QUEUE_DEPTH];
    logic [XLEN-1:0] q_pc   [QUEUE_DEPTH];
    logic            deq;
    logic            enq;

    // Handshake decode; outputs only depend on flops, so ready/redirect never reach them.
    always_comb begin
        deq = (count != '0) && inst_ready;
        enq = !redirect_valid && ((count < DEPTH_C) || deq);
    end

    // Fetch PC, pointers and occupancy; redirect wins over any enqueue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (enq) begin
                fetch_pc <= fetch_pc + XLEN'(4);
                wr_ptr   <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (enq && !deq) begin
                count <= count + CW'(1);
            end else if (deq && !enq) begin
                count <= count - CW'(1);
            end
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_inst[wr_ptr] <= imem_inst;
            q_pc[wr_ptr]   <= fetch_pc;
        end
    end

    // Head presentation, zeroed when empty so stale entries never leak out.
    always_comb begin
        imem_addr   = fetch_pc;
        queue_count = count;
        inst_valid  = (count != '0);
        inst_out    = inst_valid ? q_inst[rd_ptr] : 32'd0;
        inst_pc     = inst_valid ? q_pc[rd_ptr]   : '0;
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with an address-derived imem model.
module tb_inst_fetch_queue;

    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic [1:0]  queue_count;

    int total = 0;
    int bad   = 0;

    inst_fetch_queue #(.XLEN(64), .RESET_PC(64'd0), .QUEUE_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .queue_count    (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return 32'hC0DE_0000 ^ a[31:0];
    endfunction

    assign imem_inst = word_of(imem_addr);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Occupancy must stay within the queue depth at all times.
    always @(negedge clk) begin
        if (reset) chk("count_bound", {63'd0, (queue_count <= 2'd2)}, 64'd1);
    end

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        inst_ready     = 1'b0;

        // Held in reset.
        step();
        step();
        chk("rst_addr",  imem_addr,   64'd0);
        chk("rst_valid", inst_valid,  64'd0);
        chk("rst_count", queue_count, 64'd0);
        chk("rst_out",   inst_out,    64'd0);
        reset = 1'b1;

        // First word lands one edge after release.
        step();
        chk("rel_valid", inst_valid,  64'd1);
        chk("rel_pc",    inst_pc,     64'd0);
        chk("rel_count", queue_count, 64'd1);
        chk("rel_out",   inst_out,    {32'd0, word_of(64'd0)});

        // No ready: fills to 2 and then stalls at PC 8.
        step();
        chk("fill_count", queue_count, 64'd2);
        chk("fill_addr",  imem_addr,   64'd8);
        step();
        chk("stall_count", queue_count, 64'd2);
        chk("stall_addr",  imem_addr,   64'd8);
        chk("stall_pc",    inst_pc,     64'd0);

        // Full with one dequeue: enqueue still proceeds, no bubble.
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("fdeq_pc",    inst_pc,     64'd4);
        chk("fdeq_count", queue_count, 64'd2);
        chk("fdeq_addr",  imem_addr,   64'd12);
        chk("fdeq_out",   inst_out,    {32'd0, word_of(64'd4)});

        // Misaligned redirect while full, with decode accepting that cycle.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h43;
        inst_ready     = 1'b1;
        step();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        chk("redir_valid", inst_valid,  64'd0);
        chk("redir_count", queue_count, 64'd0);
        chk("redir_addr",  imem_addr,   64'h40);
        chk("redir_out",   inst_out,    64'd0);
        chk("redir_ipc",   inst_pc,     64'd0);
        step();
        chk("redir2_valid", inst_valid, 64'd1);
        chk("redir2_pc",    inst_pc,    64'h40);
        chk("redir2_addr",  imem_addr,  64'h44);

        // Fresh reset, then stream with ready held high.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("strm_pc",    inst_pc,     64'(4 * i));
            chk("strm_out",   inst_out,    {32'd0, word_of(64'(4 * i))});
            chk("strm_count", queue_count, 64'd1);
        end

        // PC wraps modulo 2^64.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        chk("wrap_redir_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wrap_pc",   inst_pc,   64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr", imem_addr, 64'd0);
        step();
        chk("wrap_next_pc", inst_pc, 64'd0);

        // Asynchronous reset between edges while full.
        inst_ready = 1'b0;
        step();
        step();
        chk("pre_arst_count", queue_count, 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", inst_valid,  64'd0);
        chk("arst_addr",  imem_addr,   64'd0);
        chk("arst_count", queue_count, 64'd0);
        reset = 1'b1;
        step();
        chk("arst_rel_pc", inst_pc, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
